multicycle_control: RTL and testbench

Multi-cycle control FSM for the 16-bit CPU, sitting directly upstream of the ALU: decodes the latched instruction word, sequences IF/ID/EX/MEM/WB, drives the ALU `funcCode` and datapath selects, and consumes the ALU branch flag (`bResult`) to decide branches. One instruction is in flight at a time. Memory access is handshaked, so instruction latency varies with memory response time.

---
 rtl/multicycle_control.sv | 174 +++++++++++++++++
 tb/tb_multicycle_control.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the 16-bit CPU. It steps one instruction at a time
// through IF/ID/EX/MEM/WB and drives the ALU function and the datapath selects.
module multicycle_control #(
   parameter int WORD_SIZE = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WORD_SIZE-1:0] instr,
   input  logic                 b_result,
   input  logic                 input_ready,
   input  logic                 ack_output,
   output logic [3:0]           func_code,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic                 ir_write,
   output logic                 mdr_write,
   output logic                 pc_write,
   output logic [1:0]           pc_src,
   output logic [1:0]           alu_src_b,
   output logic                 reg_write,
   output logic [1:0]           reg_dst,
   output logic [1:0]           wb_src,
   output logic                 output_port_en,
   output logic                 is_halted,
   output logic [WORD_SIZE-1:0] num_inst
);

   localparam logic [3:0] FUNC_ADD = 4'd0;
   localparam logic [3:0] FUNC_ORR = 4'd3;
   localparam logic [3:0] FUNC_LHI = 4'd8;
   localparam logic [3:0] FUNC_BNE = 4'd9;  // BNE, BEQ, BGZ, BLZ are consecutive

   typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_e;

   state_e               state_q;
   logic [WORD_SIZE-1:0] num_q;

   logic [3:0] op;
   logic [5:0] fn;
   logic       is_r, is_adi, is_ori, is_lhi, is_lwd, is_swd, is_br;
   logic       is_jmp, is_jal, is_jpr, is_jrl, is_wwd, is_hlt;
   logic       unused_bits;

   assign op          = instr[15:12];
   assign fn          = instr[5:0];
   assign unused_bits = ^instr[11:6];

   assign is_r   = (op == 4'd15) && (fn < 6'd8);
   assign is_adi = (op == 4'd4);
   assign is_ori = (op == 4'd5);
   assign is_lhi = (op == 4'd6);
   assign is_lwd = (op == 4'd7);
   assign is_swd = (op == 4'd8);
   assign is_br  = (op < 4'd4);
   assign is_jmp = (op == 4'd9);
   assign is_jal = (op == 4'd10);
   assign is_jpr = (op == 4'd15) && (fn == 6'd25);
   assign is_jrl = (op == 4'd15) && (fn == 6'd26);
   assign is_wwd = (op == 4'd15) && (fn == 6'd28);
   assign is_hlt = (op == 4'd15) && (fn == 6'd29);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IF;
         num_q   <= '0;
      end else begin
         case (state_q)
            S_IF:  if (input_ready) state_q <= S_ID;
            S_ID: begin
               num_q <= num_q + 1'b1;
               if (is_r || is_adi || is_ori || is_lhi || is_lwd || is_swd || is_br)
                  state_q <= S_EX;
               else if (is_jal || is_jrl) state_q <= S_WB;
               else if (is_hlt)           state_q <= S_HALT;
               else                       state_q <= S_IF;
            end
            S_EX: begin
               if (is_lwd || is_swd) state_q <= S_MEM;
               else if (is_br)       state_q <= S_IF;
               else                  state_q <= S_WB;
            end
            S_MEM: begin
               if (is_lwd) begin
                  if (input_ready) state_q <= S_WB;
               end else if (ack_output || !is_swd) begin
                  state_q <= S_IF;
               end
            end
            S_WB:    state_q <= S_IF;
            S_HALT:  state_q <= S_HALT;
            default: state_q <= S_IF;
         endcase
      end
   end

   // Handshake completions (fetch latch, MDR latch, branch taken) follow the
   // live input so a wait cycle never repeats a one-shot datapath update.
   always_comb begin
      func_code      = FUNC_ADD;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      ir_write       = 1'b0;
      mdr_write      = 1'b0;
      pc_write       = 1'b0;
      pc_src         = 2'd0;
      alu_src_b      = 2'd0;
      reg_write      = 1'b0;
      reg_dst        = 2'd0;
      wb_src         = 2'd0;
      output_port_en = 1'b0;
      is_halted      = 1'b0;
      if (!reset) begin
         case (state_q)
            S_IF: begin
               mem_read = 1'b1;
               ir_write = input_ready;
               pc_write = input_ready;
            end
            S_ID: begin
               if (is_jmp) begin
                  pc_write = 1'b1;
                  pc_src   = 2'd2;
               end else if (is_jpr) begin
                  pc_write = 1'b1;
                  pc_src   = 2'd3;
               end
               output_port_en = is_wwd;
            end
            S_EX: begin
               if (is_r) begin
                  func_code = fn[3:0];
               end else if (is_adi || is_lwd || is_swd) begin
                  func_code = FUNC_ADD;
                  alu_src_b = 2'd1;
               end else if (is_ori) begin
                  func_code = FUNC_ORR;
                  alu_src_b = 2'd2;
               end else if (is_lhi) begin
                  func_code = FUNC_LHI;
                  alu_src_b = 2'd2;
               end else if (is_br) begin
                  func_code = FUNC_BNE + {2'b00, op[1:0]};
                  pc_write  = b_result;
                  pc_src    = 2'd1;
               end
            end
            S_MEM: begin
               if (is_lwd) begin
                  mem_read  = 1'b1;
                  mdr_write = input_ready;
               end else if (is_swd) begin
                  mem_write = 1'b1;
               end
            end
            S_WB: begin
               reg_write = 1'b1;
               if (is_r) reg_dst = 2'd1;
               if (is_lwd) wb_src = 2'd1;
               if (is_jal || is_jrl) begin
                  reg_dst  = 2'd2;
                  wb_src   = 2'd2;
                  pc_write = 1'b1;
                  pc_src   = is_jal ? 2'd2 : 2'd3;
               end
            end
            S_HALT:  is_halted = 1'b1;
            default: ;
         endcase
      end
   end

   assign num_inst = reset ? '0 : num_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed-vector bench for multicycle_control: per-instruction cycle counts,
// strobe sequencing, handshake waits, halt and reset behaviour.
module tb_multicycle_control;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] instr;
   logic        b_result, input_ready, ack_output;
   logic [3:0]  func_code;
   logic        mem_read, mem_write, ir_write, mdr_write, pc_write;
   logic [1:0]  pc_src, alu_src_b, reg_dst, wb_src;
   logic        reg_write, output_port_en, is_halted;
   logic [15:0] num_inst;

   multicycle_control #(.WORD_SIZE(16)) dut (
      .clk(clk), .reset(reset), .instr(instr), .b_result(b_result),
      .input_ready(input_ready), .ack_output(ack_output),
      .func_code(func_code), .mem_read(mem_read), .mem_write(mem_write),
      .ir_write(ir_write), .mdr_write(mdr_write), .pc_write(pc_write),
      .pc_src(pc_src), .alu_src_b(alu_src_b), .reg_write(reg_write),
      .reg_dst(reg_dst), .wb_src(wb_src), .output_port_en(output_port_en),
      .is_halted(is_halted), .num_inst(num_inst)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       mr, mw, irw, mdrw, pcw;
      logic [1:0] pcs, asb;
      logic [3:0] fc;
      logic       rw;
      logic [1:0] rd, wb;
      logic       oe;
   } trace_t;

   trace_t tr [0:39];
   int     ncyc;
   int     c_rw, c_pcw, c_irw, c_mdrw, c_mw, c_oe;
   int     checks = 0;
   int     fails  = 0;

   // Runs one instruction from IF until the next fetch strobe, recording
   // per-cycle outputs; ncyc stays -1 if the next fetch never shows up.
   task automatic run_instr(input logic [15:0] ins, input int if_wait,
                            input int mem_wait, input logic br);
      bit seen;
      seen = 0;
      ncyc = -1;
      c_rw = 0; c_pcw = 0; c_irw = 0; c_mdrw = 0; c_mw = 0; c_oe = 0;
      instr    = ins;
      b_result = br;
      for (int k = 0; k < 40 && ncyc < 0; k++) begin
         input_ready = (k >= if_wait) &&
                       !((k >= if_wait + 3) && (k < if_wait + 3 + mem_wait));
         ack_output  = !((k >= if_wait + 3) && (k < if_wait + 3 + mem_wait));
         @(negedge clk);
         tr[k].mr = mem_read;   tr[k].mw = mem_write;  tr[k].irw = ir_write;
         tr[k].mdrw = mdr_write; tr[k].pcw = pc_write; tr[k].pcs = pc_src;
         tr[k].asb = alu_src_b; tr[k].fc = func_code;  tr[k].rw = reg_write;
         tr[k].rd = reg_dst;    tr[k].wb = wb_src;     tr[k].oe = output_port_en;
         if (ir_write && seen) begin
            ncyc = k;
            input_ready = 1'b0;
         end else begin
            if (ir_write) seen = 1;
            c_rw += int'(reg_write); c_pcw += int'(pc_write); c_irw += int'(ir_write);
            c_mdrw += int'(mdr_write); c_mw += int'(mem_write); c_oe += int'(output_port_en);
         end
         @(posedge clk); #1;
      end
      input_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; instr = 16'hF1C0; b_result = 1'b1;
      input_ready = 1'b1; ack_output = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({func_code, mem_read, mem_write, ir_write, mdr_write, pc_write, pc_src, alu_src_b,
           reg_write, reg_dst, wb_src, output_port_en, is_halted, num_inst} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: mem_read=%b ir_write=%b pc_write=%b num_inst=%h, required all 0",
                  mem_read, ir_write, pc_write, num_inst);
      end
      @(posedge clk); #1;
      reset = 1'b0; input_ready = 1'b0;
      @(negedge clk);
      checks++;
      if ({mem_read, ir_write, num_inst} !== {1'b1, 1'b0, 16'h0000}) begin
         fails++;
         $display("FAIL reset_release: mem_read=%b ir_write=%b num_inst=%h, required 1 0 0000",
                  mem_read, ir_write, num_inst);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_add();
      run_instr(16'hF1C0, 0, 0, 1'b0);
      checks++;
      if (ncyc !== 4) begin fails++; $display("FAIL add_cycles: got %0d required 4", ncyc); end
      checks++;
      if ({tr[0].mr, tr[0].irw, tr[0].pcw, tr[0].pcs} !== 5'b11100) begin
         fails++; $display("FAIL add_fetch: mr/irw/pcw/pcs got %b required 11100",
                           {tr[0].mr, tr[0].irw, tr[0].pcw, tr[0].pcs});
      end
      checks++;
      if ({tr[2].fc, tr[2].asb} !== {4'd0, 2'd0}) begin
         fails++; $display("FAIL add_ex: func=%0d asb=%0d required 0 0", tr[2].fc, tr[2].asb);
      end
      checks++;
      if ({tr[3].rw, tr[3].rd, tr[3].wb, c_rw} !== {1'b1, 2'd1, 2'd0, 32'd1}) begin
         fails++; $display("FAIL add_wb: rw=%b rd=%0d wb=%0d pulses=%0d required 1 1 0 1",
                           tr[3].rw, tr[3].rd, tr[3].wb, c_rw);
      end
      checks++;
      if (num_inst !== 16'd1) begin fails++; $display("FAIL add_num_inst: got %h required 0001", num_inst); end
   endtask

   task automatic test_alu_variants();
      run_instr(16'hF1C7, 0, 0, 1'b0);  // SHR
      checks++;
      if ({ncyc[3:0], tr[2].fc, tr[3].rd} !== {4'd4, 4'd7, 2'd1}) begin
         fails++; $display("FAIL shr: cycles=%0d func=%0d rd=%0d required 4 7 1", ncyc, tr[2].fc, tr[3].rd);
      end
      run_instr(16'h4105, 0, 0, 1'b0);  // ADI
      checks++;
      if ({ncyc[3:0], tr[2].fc, tr[2].asb, tr[3].rd} !== {4'd4, 4'd0, 2'd1, 2'd0}) begin
         fails++; $display("FAIL adi: cycles=%0d func=%0d asb=%0d rd=%0d required 4 0 1 0",
                           ncyc, tr[2].fc, tr[2].asb, tr[3].rd);
      end
      run_instr(16'h5105, 0, 0, 1'b0);  // ORI
      checks++;
      if ({tr[2].fc, tr[2].asb, tr[3].rw, tr[3].rd} !== {4'd3, 2'd2, 1'b1, 2'd0}) begin
         fails++; $display("FAIL ori: func=%0d asb=%0d rw=%b rd=%0d required 3 2 1 0",
                           tr[2].fc, tr[2].asb, tr[3].rw, tr[3].rd);
      end
      run_instr(16'h6155, 0, 0, 1'b0);  // LHI
      checks++;
      if ({tr[2].fc, tr[2].asb} !== {4'd8, 2'd2}) begin
         fails++; $display("FAIL lhi: func=%0d asb=%0d required 8 2", tr[2].fc, tr[2].asb);
      end
   endtask

   task automatic test_lwd();
      bit cont;
      run_instr(16'h7104, 2, 3, 1'b0);
      checks++;
      if (ncyc !== 10) begin fails++; $display("FAIL lwd_cycles: got %0d required 10", ncyc); end
      cont = tr[0].mr && tr[1].mr && tr[2].mr && tr[5].mr && tr[6].mr && tr[7].mr && tr[8].mr
             && !tr[0].irw && !tr[1].irw && !tr[5].mdrw && !tr[7].mdrw;
      checks++;
      if (cont !== 1'b1) begin fails++; $display("FAIL lwd_wait_hold: got %b required 1", cont); end
      checks++;
      if ({c_irw, c_mdrw, c_rw} !== {32'd1, 32'd1, 32'd1}) begin
         fails++; $display("FAIL lwd_pulses: ir=%0d mdr=%0d reg=%0d required 1 1 1", c_irw, c_mdrw, c_rw);
      end
      checks++;
      if ({tr[4].fc, tr[4].asb, tr[8].mdrw, tr[9].rw, tr[9].wb, tr[9].rd} !==
          {4'd0, 2'd1, 1'b1, 1'b1, 2'd1, 2'd0}) begin
         fails++; $display("FAIL lwd_sel: func=%0d asb=%0d mdr=%b rw=%b wb=%0d rd=%0d required 0 1 1 1 1 0",
                           tr[4].fc, tr[4].asb, tr[8].mdrw, tr[9].rw, tr[9].wb, tr[9].rd);
      end
   endtask

   task automatic test_swd();
      run_instr(16'h8104, 0, 0, 1'b0);
      checks++;
      if ({ncyc[3:0], tr[3].mw, c_mw[3:0], c_rw[3:0]} !== {4'd4, 1'b1, 4'd1, 4'd0}) begin
         fails++; $display("FAIL swd: cycles=%0d mw=%b mw_pulses=%0d rw=%0d required 4 1 1 0",
                           ncyc, tr[3].mw, c_mw, c_rw);
      end
      run_instr(16'h8104, 0, 2, 1'b0);
      checks++;
      if ({ncyc[3:0], tr[3].mw, tr[4].mw, tr[5].mw, c_rw[3:0]} !== {4'd6, 3'b111, 4'd0}) begin
         fails++; $display("FAIL swd_wait: cycles=%0d mw=%b%b%b rw=%0d required 6 111 0",
                           ncyc, tr[3].mw, tr[4].mw, tr[5].mw, c_rw);
      end
   endtask

   task automatic test_branch();
      run_instr(16'h1105, 0, 0, 1'b1);  // BEQ taken
      checks++;
      if ({ncyc[3:0], tr[2].fc, tr[2].asb, tr[2].pcw, tr[2].pcs} !== {4'd3, 4'd10, 2'd0, 1'b1, 2'd1}) begin
         fails++; $display("FAIL beq_taken: cycles=%0d func=%0d asb=%0d pcw=%b pcs=%0d required 3 10 0 1 1",
                           ncyc, tr[2].fc, tr[2].asb, tr[2].pcw, tr[2].pcs);
      end
      run_instr(16'h1105, 0, 0, 1'b0);  // BEQ not taken
      checks++;
      if ({ncyc[3:0], tr[2].pcw, c_pcw[3:0], c_rw[3:0]} !== {4'd3, 1'b0, 4'd1, 4'd0}) begin
         fails++; $display("FAIL beq_not_taken: cycles=%0d pcw=%b pc_pulses=%0d rw=%0d required 3 0 1 0",
                           ncyc, tr[2].pcw, c_pcw, c_rw);
      end
      run_instr(16'h3105, 0, 0, 1'b1);  // BLZ
      checks++;
      if ({ncyc[3:0], tr[2].fc} !== {4'd3, 4'd12}) begin
         fails++; $display("FAIL blz: cycles=%0d func=%0d required 3 12", ncyc, tr[2].fc);
      end
   endtask

   task automatic test_jumps();
      run_instr(16'h9123, 0, 0, 1'b0);  // JMP
      checks++;
      if ({ncyc[3:0], tr[1].pcw, tr[1].pcs, c_rw[3:0]} !== {4'd2, 1'b1, 2'd2, 4'd0}) begin
         fails++; $display("FAIL jmp: cycles=%0d pcw=%b pcs=%0d rw=%0d required 2 1 2 0",
                           ncyc, tr[1].pcw, tr[1].pcs, c_rw);
      end
      run_instr(16'hF019, 0, 0, 1'b0);  // JPR
      checks++;
      if ({ncyc[3:0], tr[1].pcw, tr[1].pcs} !== {4'd2, 1'b1, 2'd3}) begin
         fails++; $display("FAIL jpr: cycles=%0d pcw=%b pcs=%0d required 2 1 3", ncyc, tr[1].pcw, tr[1].pcs);
      end
      run_instr(16'hF01C, 0, 0, 1'b0);  // WWD
      checks++;
      if ({ncyc[3:0], tr[1].oe, c_oe[3:0], c_rw[3:0]} !== {4'd2, 1'b1, 4'd1, 4'd0}) begin
         fails++; $display("FAIL wwd: cycles=%0d oe=%b oe_pulses=%0d rw=%0d required 2 1 1 0",
                           ncyc, tr[1].oe, c_oe, c_rw);
      end
      run_instr(16'hA123, 0, 0, 1'b0);  // JAL
      checks++;
      if ({ncyc[3:0], tr[2].rw, tr[2].rd, tr[2].wb, tr[2].pcw, tr[2].pcs} !==
          {4'd3, 1'b1, 2'd2, 2'd2, 1'b1, 2'd2}) begin
         fails++; $display("FAIL jal: cycles=%0d rw=%b rd=%0d wb=%0d pcw=%b pcs=%0d required 3 1 2 2 1 2",
                           ncyc, tr[2].rw, tr[2].rd, tr[2].wb, tr[2].pcw, tr[2].pcs);
      end
      run_instr(16'hF01A, 0, 0, 1'b0);  // JRL
      checks++;
      if ({ncyc[3:0], tr[2].rw, tr[2].rd, tr[2].pcw, tr[2].pcs} !== {4'd3, 1'b1, 2'd2, 1'b1, 2'd3}) begin
         fails++; $display("FAIL jrl: cycles=%0d rw=%b rd=%0d pcw=%b pcs=%0d required 3 1 2 1 3",
                           ncyc, tr[2].rw, tr[2].rd, tr[2].pcw, tr[2].pcs);
      end
      run_instr(16'hF020, 0, 0, 1'b0);  // undefined func: NOP
      checks++;
      if ({ncyc[3:0], c_rw[3:0], c_pcw[3:0], c_oe[3:0], c_mw[3:0]} !== {4'd2, 4'd0, 4'd1, 4'd0, 4'd0}) begin
         fails++; $display("FAIL nop: cycles=%0d rw=%0d pcw=%0d oe=%0d mw=%0d required 2 0 1 0 0",
                           ncyc, c_rw, c_pcw, c_oe, c_mw);
      end
   endtask

   task automatic test_halt();
      int bad;
      bad = 0;
      instr = 16'hF01D; input_ready = 1'b1; ack_output = 1'b1; b_result = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      for (int i = 0; i < 22; i++) begin
         @(negedge clk);
         if (!is_halted || mem_read || mem_write || ir_write || mdr_write || pc_write ||
             reg_write || output_port_en) bad++;
         @(posedge clk); #1;
      end
      checks++;
      if (bad !== 0) begin fails++; $display("FAIL halt_hold: bad cycles %0d required 0", bad); end
      checks++;
      if (num_inst === 16'd0) begin fails++; $display("FAIL halt_count: num_inst %h required nonzero", num_inst); end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({is_halted, mem_read, num_inst} !== 18'd0) begin
         fails++; $display("FAIL halt_reset: halted=%b mem_read=%b num_inst=%h required 0 0 0000",
                           is_halted, mem_read, num_inst);
      end
      @(posedge clk); #1;
      reset = 1'b0; input_ready = 1'b0;
      @(negedge clk);
      checks++;
      if ({is_halted, mem_read, num_inst} !== {1'b0, 1'b1, 16'h0000}) begin
         fails++; $display("FAIL halt_exit: halted=%b mem_read=%b num_inst=%h required 0 1 0000",
                           is_halted, mem_read, num_inst);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_swd();
      int bad;
      bad = 0;
      instr = 16'h8104; input_ready = 1'b1; ack_output = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (mem_write !== 1'b1) begin fails++; $display("FAIL swd_pending: mem_write %b required 1", mem_write); end
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({mem_write, mem_read, pc_write, reg_write} !== 4'b0000) begin
         fails++; $display("FAIL mid_reset: mw/mr/pcw/rw got %b required 0000",
                           {mem_write, mem_read, pc_write, reg_write});
      end
      @(posedge clk); #1;
      reset = 1'b0; input_ready = 1'b0; ack_output = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (mem_write || pc_write || reg_write || !mem_read) bad++;
         @(posedge clk); #1;
      end
      checks++;
      if (bad !== 0) begin fails++; $display("FAIL mid_reset_abort: bad cycles %0d required 0", bad); end
      run_instr(16'hF1C0, 0, 0, 1'b0);
      checks++;
      if ({ncyc[3:0], c_mw[3:0], num_inst} !== {4'd4, 4'd0, 16'd1}) begin
         fails++; $display("FAIL mid_reset_refetch: cycles=%0d mw=%0d num_inst=%h required 4 0 0001",
                           ncyc, c_mw, num_inst);
      end
   endtask

   task automatic test_num_wrap();
      input_ready = 1'b0;
      @(negedge clk);
      dut.num_q = 16'hFFFF;
      #1;
      checks++;
      if (num_inst !== 16'hFFFF) begin fails++; $display("FAIL wrap_preload: got %h required ffff", num_inst); end
      @(posedge clk); #1;
      run_instr(16'h9000, 0, 0, 1'b0);
      checks++;
      if (num_inst !== 16'h0000) begin fails++; $display("FAIL wrap: got %h required 0000", num_inst); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_alu_variants();
      test_lwd();
      test_swd();
      test_branch();
      test_jumps();
      test_halt();
      test_reset_mid_swd();
      test_num_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
